// File: rtl/rs_decode_seq.sv
// Symbol-serial sequencer around an external RS decoder core: latches a codeword of runtime length,
// feeds it to the core, collects the per-symbol error pattern and returns corrected data plus status.
module rs_decode_seq #(
  parameter int SYM_W   = 8,
  parameter int N_MAX   = 200,
  parameter int LEN_W   = $clog2(N_MAX + 1),
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clrn,
  input  logic                   scan_mode,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [N_MAX*SYM_W-1:0] data_in,
  output logic                   ready,
  output logic                   cfg_err,
  output logic [N_MAX*SYM_W-1:0] err_vec,
  output logic [N_MAX*SYM_W-1:0] corr_data,
  output logic [LEN_W-1:0]       err_cnt,
  output logic                   with_error,
  output logic                   timeout,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [SYM_W-1:0]       core_x,
  output logic                   core_en,
  output logic [7:0]             core_k,
  output logic                   core_clrn,
  input  logic [SYM_W-1:0]       core_error,
  input  logic                   core_valid,
  input  logic                   core_with_error,
  output logic [1:0]             dbg_state
);

  localparam int DW   = N_MAX * SYM_W;
  localparam int IW   = $clog2(DW);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [DW-1:0]     data_q;
  logic [LEN_W-1:0]  idx_q;
  logic [WD_W-1:0]   wdog_q;
  logic [DW-1:0]     err_vec_q;
  logic [DW-1:0]     corr_q;
  logic [LEN_W-1:0]  err_cnt_q;
  logic              with_error_q;
  logic              timeout_q;
  logic              cfg_err_q;

  logic              len_ok;
  logic              is_last;
  logic [IW-1:0]     sym_lo;
  logic              accept, cfg_bad, cap, wdog_tick, wdog_expire;

  assign len_ok  = (len != '0) && (len <= LEN_W'(N_MAX));
  assign is_last = (idx_q == len_q - LEN_W'(1));
  assign sym_lo  = IW'(int'(idx_q) * SYM_W);

  // Handshakes: start is taken on a clock edge where start && ready; out_valid then stays high
  // until an edge with out_ack high, and the next start is accepted on the edge after that.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    cfg_bad     = 1'b0;
    cap         = 1'b0;
    wdog_tick   = 1'b0;
    wdog_expire = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && len_ok) begin
          accept  = 1'b1;
          state_d = FEED;
        end else if (start) begin
          cfg_bad = 1'b1;
        end
      end
      FEED: begin
        if (is_last) state_d = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          cap = 1'b1;
          if (is_last) state_d = DONE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          wdog_expire = 1'b1;
          state_d     = DONE;
        end else begin
          wdog_tick = 1'b1;
        end
      end
      DONE: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      wdog_q       <= '0;
      err_vec_q    <= '0;
      corr_q       <= '0;
      err_cnt_q    <= '0;
      with_error_q <= 1'b0;
      timeout_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else if (!clrn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      wdog_q       <= '0;
      err_vec_q    <= '0;
      corr_q       <= '0;
      err_cnt_q    <= '0;
      with_error_q <= 1'b0;
      timeout_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_bad;
      if (accept) begin
        len_q        <= len;
        data_q       <= data_in;
        idx_q        <= '0;
        err_cnt_q    <= '0;
        with_error_q <= 1'b0;
        timeout_q    <= 1'b0;
        err_vec_q    <= '0;
        corr_q       <= '0;
      end
      if (state_q == FEED) begin
        if (is_last) begin
          idx_q  <= '0;
          wdog_q <= '0;
        end else begin
          idx_q <= idx_q + LEN_W'(1);
        end
      end
      if (cap) begin
        err_vec_q[sym_lo +: SYM_W] <= core_error;
        corr_q[sym_lo +: SYM_W]    <= data_q[sym_lo +: SYM_W] ^ core_error;
        if (core_error != '0 && err_cnt_q != '1) err_cnt_q <= err_cnt_q + LEN_W'(1);
        idx_q  <= idx_q + LEN_W'(1);
        wdog_q <= '0;
      end
      if (wdog_tick)   wdog_q    <= wdog_q + WD_W'(1);
      if (wdog_expire) timeout_q <= 1'b1;
      // The core's flag only counts while it is actually working on our codeword.
      if ((state_q == FEED || state_q == WAIT) && core_with_error) with_error_q <= 1'b1;
    end
  end

  always_comb begin
    core_x = '0;
    if (state_q == FEED) core_x = data_q[sym_lo +: SYM_W];
  end

  assign ready      = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign core_en    = (state_q == FEED);
  assign core_k     = 8'(len_q);
  assign core_clrn  = rst_n & (clrn | scan_mode);
  assign cfg_err    = cfg_err_q;
  assign err_vec    = err_vec_q;
  assign corr_data  = corr_q;
  assign err_cnt    = err_cnt_q;
  assign with_error = with_error_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rs_decode_seq.sv
// Self-checking bench for rs_decode_seq: directed corner runs plus randomized runs against a
// symbol-array reference model and an expected-symbol queue for the core feed.
module tb_rs_decode_seq;

  localparam int SYM_W   = 8;
  localparam int N_MAX   = 200;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 1024;
  localparam int DW      = N_MAX * SYM_W;

  logic             clk = 1'b0;
  logic             rst_n, clrn, scan_mode, start, out_ack;
  logic [LEN_W-1:0] len;
  logic [DW-1:0]    data_in;
  logic             ready, cfg_err, with_error, timeout, out_valid, core_en, core_clrn;
  logic [DW-1:0]    err_vec, corr_data;
  logic [LEN_W-1:0] err_cnt;
  logic [SYM_W-1:0] core_x, core_error;
  logic [7:0]       core_k;
  logic             core_valid, core_with_error;
  logic [1:0]       dbg_state;

  rs_decode_seq #(.SYM_W(SYM_W), .N_MAX(N_MAX), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .clrn(clrn), .scan_mode(scan_mode), .start(start), .len(len),
    .data_in(data_in), .ready(ready), .cfg_err(cfg_err), .err_vec(err_vec), .corr_data(corr_data),
    .err_cnt(err_cnt), .with_error(with_error), .timeout(timeout), .out_valid(out_valid),
    .out_ack(out_ack), .core_x(core_x), .core_en(core_en), .core_k(core_k), .core_clrn(core_clrn),
    .core_error(core_error), .core_valid(core_valid), .core_with_error(core_with_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench time limit");
  end

  int n_vec = 0;
  int n_err = 0;

  logic [SYM_W-1:0] exp_q[$];
  logic [SYM_W-1:0] data_m[N_MAX];
  logic [SYM_W-1:0] errs_m[N_MAX];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    for (int i = 0; i < N_MAX; i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(got[i*SYM_W +: SYM_W]), 64'(exp[i*SYM_W +: SYM_W]));
  endtask

  task automatic rand_data();
    for (int i = 0; i < N_MAX; i++) data_m[i] = SYM_W'($urandom);
  endtask

  task automatic rand_errs(input int pct);
    for (int i = 0; i < N_MAX; i++)
      errs_m[i] = ($urandom_range(0, 99) < pct) ? SYM_W'($urandom_range(1, 255)) : '0;
  endtask

  // One full codeword run. Starts and ends at a falling edge with the DUT idle.
  task automatic run(input int L, input int D, input bit contig, input int nvalid,
                     input int ack_dly, input bit hold_start, input int we_cyc);
    logic [DW-1:0] pk, ev_p, cv_p;
    int cyc, k, last_v, ov_cyc, cnt;
    bit exp_we;
    pk = '0;
    for (int i = 0; i < N_MAX; i++) pk[i*SYM_W +: SYM_W] = data_m[i];
    chk("ready_before_start", ready, 1);
    start = 1'b1; len = LEN_W'(L); data_in = pk;
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(data_m[i]);
    @(negedge clk); cyc = 1;
    start = 1'b0; len = LEN_W'($urandom); data_in = {50{$urandom}};
    exp_we = 1'b0;
    chk("ready_busy", ready, 0);
    chk("core_k", core_k, 64'(L));
    chk("err_vec_cleared", 64'(|err_vec), 0);
    chk("corr_cleared", 64'(|corr_data), 0);
    chk("err_cnt_cleared", err_cnt, 0);
    chk("timeout_cleared", timeout, 0);
    chk("with_error_cleared", with_error, 0);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("core_en_feed%0d", i), core_en, 1);
      chk($sformatf("core_x%0d", i), core_x, exp_q.pop_front());
      core_valid = 1'($urandom_range(0, 1));
      core_error = SYM_W'($urandom);
      out_ack = 1'($urandom_range(0, 1));
      core_with_error = (cyc == we_cyc);
      if (core_with_error) exp_we = 1'b1;
      @(negedge clk); cyc++;
    end
    chk("core_en_wait", core_en, 0);
    chk("core_x_wait", core_x, 0);
    k = 0; last_v = L; ov_cyc = -1;
    for (int t = 0; t < 3000; t++) begin
      if (out_valid) begin
        ov_cyc = cyc;
        break;
      end
      core_with_error = (cyc == we_cyc);
      if (core_with_error) exp_we = 1'b1;
      out_ack = 1'($urandom_range(0, 1));
      if (k < nvalid && t >= D && (contig || $urandom_range(0, 2) != 0)) begin
        core_valid = 1'b1; core_error = errs_m[k]; k++; last_v = cyc;
      end else begin
        core_valid = 1'b0; core_error = SYM_W'($urandom);
      end
      @(negedge clk); cyc++;
    end
    core_valid = 1'b0; core_with_error = 1'b0; out_ack = 1'b0;
    chk("out_valid_seen", 64'(ov_cyc >= 0), 1);
    if (k == L) chk("done_cycle", 64'(ov_cyc), 64'(last_v + 1));
    else        chk("timeout_cycle", 64'(ov_cyc), 64'(last_v + TIMEOUT + 1));
    if (contig && nvalid == L) chk("latency", 64'(ov_cyc), 64'(2 * L + D + 1));
    ev_p = '0; cv_p = '0; cnt = 0;
    for (int i = 0; i < k; i++) begin
      ev_p[i*SYM_W +: SYM_W] = errs_m[i];
      cv_p[i*SYM_W +: SYM_W] = data_m[i] ^ errs_m[i];
      if (errs_m[i] != 0) cnt++;
    end
    chk_vec("err_vec", err_vec, ev_p);
    chk_vec("corr_data", corr_data, cv_p);
    chk("err_cnt", err_cnt, 64'(cnt));
    chk("with_error", with_error, 64'(exp_we));
    chk("timeout", timeout, 64'(k < L));
    for (int t = 0; t < ack_dly; t++) begin
      chk("out_valid_hold", out_valid, 1);
      core_valid = 1'($urandom_range(0, 1));
      core_error = SYM_W'($urandom);
      core_with_error = 1'($urandom_range(0, 1));
      if (hold_start) begin
        start = 1'b1; len = LEN_W'($urandom_range(1, N_MAX)); data_in = {50{$urandom}};
      end
      @(negedge clk);
    end
    chk("out_valid_pre_ack", out_valid, 1);
    core_valid = 1'b0; core_with_error = 1'b0;
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    if (!hold_start) start = 1'b0;
    chk("ready_after_ack", ready, 1);
    chk("out_valid_after_ack", out_valid, 0);
    chk("err_vec_held", 64'(err_vec != ev_p), 0);
    chk("corr_held", 64'(corr_data != cv_p), 0);
    chk("err_cnt_held", err_cnt, 64'(cnt));
    chk("with_error_held", with_error, 64'(exp_we));
  endtask

  task automatic clr_test(input bit scan);
    bit seen;
    scan_mode = scan;
    rand_data();
    start = 1'b1; len = 10; data_in = {50{$urandom}};
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("clr_core_en_before", core_en, 1);
    clrn = 1'b0;
    #1;
    chk("clr_core_clrn_now", core_clrn, 64'(scan));
    @(negedge clk);
    chk("clr_ready", ready, 1);
    chk("clr_core_en", core_en, 0);
    chk("clr_core_x", core_x, 0);
    chk("clr_core_clrn", core_clrn, 64'(scan));
    chk("clr_out_valid", out_valid, 0);
    chk("clr_core_k", core_k, 0);
    clrn = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      core_valid = 1'($urandom_range(0, 1)); core_error = SYM_W'($urandom);
      @(negedge clk);
      if (out_valid || core_en) seen = 1'b1;
    end
    core_valid = 1'b0;
    chk("clr_no_activity", seen, 0);
    chk("clr_core_clrn_back", core_clrn, 1);
    scan_mode = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clrn = 1'b1; scan_mode = 1'b0; start = 1'b0; len = '0; data_in = '0;
    out_ack = 1'b0; core_error = '0; core_valid = 1'b0; core_with_error = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_core_clrn", core_clrn, 0);
    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_vec", 64'(|err_vec), 0);
    chk("rst_corr", 64'(|corr_data), 0);
    chk("rst_flags", {with_error, timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("core_clrn_run", core_clrn, 1);

    // full-length clean codeword
    rand_data(); rand_errs(0);
    run(200, 2, 1, 200, 0, 0, -1);

    // two known errors, core flag raised while waiting
    rand_data(); rand_errs(0);
    errs_m[3] = 8'h5A; errs_m[15] = 8'h01;
    run(16, 0, 1, 16, 1, 0, 20);

    // rejected lengths
    start = 1'b1; len = 0;
    @(negedge clk);
    chk("cfg_err_len0", cfg_err, 1); chk("cfg_ready0", ready, 1); chk("cfg_en0", core_en, 0);
    len = 201;
    @(negedge clk);
    chk("cfg_err_len201", cfg_err, 1); chk("cfg_ready201", ready, 1); chk("cfg_en201", core_en, 0);
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err_drop", cfg_err, 0); chk("cfg_en_after", core_en, 0); chk("cfg_ready_after", ready, 1);

    // core stalls after 5 of 8 symbols
    rand_data(); rand_errs(60);
    run(8, 0, 1, 5, 0, 0, 2);

    clr_test(1'b0);
    clr_test(1'b1);

    // late ack with start held, then the back-to-back run
    rand_data(); rand_errs(30);
    run(12, 1, 1, 12, 10, 1, -1);
    rand_data(); rand_errs(30);
    run(int'($urandom_range(1, 40)), 0, 1, 0 + 0, 0, 0, -1);

    for (int r = 0; r < 10; r++) begin
      int L;
      L = int'($urandom_range(1, N_MAX));
      rand_data(); rand_errs(30);
      run(L, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), L, int'($urandom_range(0, 4)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 2 * L + 4)));
    end
    start = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_decode_seq.md
Name: rs_decode_seq

Overview:
- Parametrised successor to the fixed 200-byte RS decode sequencer.
- Latches one codeword of programmable length (1..N_MAX symbols of SYM_W bits) and streams it symbol-serially into an external RS decoder core.
- Collects the per-symbol error pattern and returns the error vector, the corrected codeword and status (error count, with_error, timeout).
- Sits between a register/bus front-end and the rsdec core; adds runtime length, in-place correction, a watchdog and an output ack handshake.

Parameters:
- SYM_W, 8, symbol width in bits.
- N_MAX, 200, maximum codeword length in symbols; sizes the flat data vectors.
- LEN_W, $clog2(N_MAX+1), width of length fields.
- TIMEOUT, 1024, maximum idle cycles with core_valid low in WAIT before abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clrn  in  1  synchronous active-low clear.
- scan_mode  in  1  forces core_clrn high during scan.
- start  in  1  request; accepted only when ready=1.
- len  in  LEN_W  codeword length in symbols, sampled at accept.
- data_in  in  N_MAX*SYM_W  codeword; symbol i at [i*SYM_W +: SYM_W]; sampled at accept.
- ready  out  1  idle, can accept start.
- cfg_err  out  1  1-cycle pulse: start rejected for bad len.
- err_vec  out  N_MAX*SYM_W  error pattern per symbol.
- corr_data  out  N_MAX*SYM_W  data_in XOR err_vec.
- err_cnt  out  LEN_W  number of nonzero error symbols.
- with_error  out  1  sticky OR of core_with_error during the run.
- timeout  out  1  run aborted by watchdog.
- out_valid  out  1  results valid; held until out_ack.
- out_ack  in  1  consumer acknowledge.
- core_x  out  SYM_W  symbol to core.
- core_en  out  1  core enable.
- core_k  out  8  latched len, to core k port.
- core_clrn  out  1  rst_n & (clrn | scan_mode).
- core_error  in  SYM_W  error symbol from core.
- core_valid  in  1  core_error is valid this cycle.
- core_with_error  in  1  core error flag.

Behaviour:
- Reset (rst_n=0, async) or clrn=0 (sync, any state): state IDLE; ready=1; all other outputs 0; internal latches and counters 0. The core clear is core_clrn, combinational.
- FSM states: IDLE, FEED, WAIT, DONE.
- IDLE:
  - start=1 with 1<=len<=N_MAX: latch data_in and len; idx=0; err_cnt=0; with_error=0; timeout=0; ready<=0; go to FEED.
  - start=1 with len=0 or len>N_MAX: stay in IDLE; cfg_err=1 for one cycle; no other state changes.
  - Previous err_vec and corr_data hold until the next accept, then clear to 0.
- FEED:
  - Starting the cycle after accept, for exactly len consecutive cycles: core_en=1 and core_x = symbol idx; idx increments.
  - After the last symbol: core_en<=0, idx<=0, watchdog<=0, go to WAIT.
  - core_valid during FEED is ignored.
- WAIT, on each core_valid=1 cycle:
  - err_vec[idx] <= core_error.
  - corr_data[idx] <= data[idx] ^ core_error.
  - err_cnt increments if core_error != 0.
  - idx increments; watchdog resets.
  - When the captured symbol is number len-1, go to DONE.
- WAIT, on each core_valid=0 cycle: watchdog increments. Reaching TIMEOUT sets timeout=1 and goes to DONE with partial results.
- with_error is set in FEED or WAIT whenever core_with_error=1 and cleared only at the next accept.
- DONE: out_valid=1 held. When out_ack=1: out_valid<=0, ready<=1, go to IDLE; a new start is accepted the following cycle. out_ack outside DONE is ignored.
- Latency (core_valid contiguous): accept at cycle 0; feed cycles 1..len; out_valid = 1 at cycle len + D + len + 1, where D is the core's first-valid delay.
- Counters saturate at width; err_cnt <= len is always true.
- Symbols >= len in err_vec and corr_data stay 0.
- clrn=0 mid-run aborts immediately with no out_valid.
- start while ready=0 is ignored.

Test Plan:
- len=200, all-zero core_error, contiguous core_valid -> out_valid after full latency; err_cnt=0; corr_data=data_in; with_error=0; timeout=0.
- len=16; core_error=8'h5A at symbol 3 and 8'h01 at symbol 15 -> err_cnt=2; err_vec bytes 3/15 set; corr_data[3]=data[3]^8'h5A; bytes 16..199 = 0.
- start with len=0, then len=201 -> cfg_err pulses twice; ready stays 1; core_en never asserts.
- len=8, core stalls after 5 valids for TIMEOUT cycles -> timeout=1; out_valid=1; err_vec holds 5 captured symbols.
- clrn=0 in the 4th FEED cycle -> next cycle: IDLE, ready=1, core_en=0, core_clrn=0. With scan_mode=1: core_clrn=1 while the block still clears.
- out_ack delayed 10 cycles with start held high -> out_valid held 10 cycles; new run accepted exactly 1 cycle after the ack.
